// File: rtl/sram_ctrl_param.sv
// SRAM controller: timed word read/write cycles with programmable wait count.
// Optional multi-word read bursts when SRAM_BURST_EN is defined.
module sram_ctrl_param #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_AW     = 17,
  parameter logic [31:0] BASE_ADDR   = 32'h400,
  parameter int          WAIT_CYCLES = 4,
  parameter int          BURST_LEN   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        read_en,
  input  logic                        write_en,
  input  logic [31:0]                 address,
  input  logic [DATA_W-1:0]           write_data,
`ifdef SRAM_BURST_EN
  output logic [DATA_W*BURST_LEN-1:0] read_data,
`else
  output logic [DATA_W-1:0]           read_data,
`endif
  output logic                        ready,
  inout  wire  [DATA_W-1:0]           sram_dq,
  output logic [SRAM_AW-1:0]          sram_addr,
  output logic                        sram_we_n,
  output logic                        sram_oe_n
);

  localparam int BW = $clog2(DATA_W / 8);
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state, state_nx;
  logic [3:0] wait_cnt;
  logic [DATA_W-1:0] wdata;
  logic [31:0] word_full;
  logic [SRAM_AW-1:0] word_addr;
  logic [SRAM_AW-1:0] start_addr;
  logic last_wait;
  logic more;
  logic unused;

  assign word_full = (address - BASE_ADDR) >> BW;
  assign word_addr = word_full[SRAM_AW-1:0];
  assign unused    = ^word_full[31:SRAM_AW];
  assign last_wait = (wait_cnt == WLAST);

`ifdef SRAM_BURST_EN
  localparam int IW = $clog2(BURST_LEN);
  localparam logic [IW-1:0] ILAST = IW'(BURST_LEN - 1);
  localparam logic [SRAM_AW-1:0] AMASK = SRAM_AW'(BURST_LEN - 1);

  logic [IW-1:0] word_idx;

  // Bursts start on a BURST_LEN-word boundary; writes stay unaligned.
  assign start_addr = read_en ? (word_addr & ~AMASK) : word_addr;
  assign more       = (word_idx != ILAST);
`else
  localparam int unused_bl = BURST_LEN;

  assign start_addr = word_addr;
  assign more       = 1'b0;
`endif

  assign sram_we_n = (state != WR);
  assign sram_oe_n = (state != RD);
  assign sram_dq   = (state == WR) ? wdata : {DATA_W{1'bz}};

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~(read_en | write_en);
        if (read_en)
          state_nx = RD;
        else if (write_en)
          state_nx = WR;
      end
      RD:   if (last_wait && !more) state_nx = DONE;
      WR:   if (last_wait) state_nx = DONE;
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_n) ready = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wdata     <= '0;
      sram_addr <= '0;
      read_data <= '0;
`ifdef SRAM_BURST_EN
      word_idx  <= '0;
`endif
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (read_en | write_en) begin
            sram_addr <= start_addr;
            wdata     <= write_data;
            wait_cnt  <= '0;
`ifdef SRAM_BURST_EN
            word_idx  <= '0;
`endif
          end
        end
        RD: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (last_wait) begin
`ifdef SRAM_BURST_EN
            read_data[word_idx*DATA_W +: DATA_W] <= sram_dq;
            if (more) begin
              sram_addr <= sram_addr + SRAM_AW'(1);
              word_idx  <= word_idx + IW'(1);
              wait_cnt  <= '0;
            end
`else
            read_data <= sram_dq;
`endif
          end
        end
        WR:      wait_cnt <= wait_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Scoreboard bench for sram_ctrl_param against an SRAM model and a
// word-array reference of memory contents.
module tb_sram_ctrl_param;
  localparam int DW = 32;
  localparam int AW = 17;
  localparam int W  = 4;
  localparam int BL = 2;
  localparam logic [31:0] BASE = 32'h400;
`ifdef SRAM_BURST_EN
  localparam int RW = BL;
`else
  localparam int RW = 1;
`endif

  logic clk = 0;
  logic rst_n = 0;
  logic read_en = 0;
  logic write_en = 0;
  logic [31:0] address = 0;
  logic [DW-1:0] write_data = 0;
  logic [DW*RW-1:0] read_data;
  logic ready;
  wire  [DW-1:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic sram_we_n;
  logic sram_oe_n;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:255];

  typedef struct {
    bit              rd;
    logic [AW-1:0]   word;
    logic [DW-1:0]   wdata;
    logic [DW*RW-1:0] rdata;
    int              lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  bit mon_en = 0;
  int lat = 0;
  int we_cnt = 0;
  int oe_cnt = 0;

  sram_ctrl_param #(
    .DATA_W(DW), .SRAM_AW(AW), .BASE_ADDR(BASE),
    .WAIT_CYCLES(W), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_dq(sram_dq), .sram_addr(sram_addr),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  assign sram_dq = !sram_oe_n ? mem[sram_addr] : {DW{1'bz}};

  always @(posedge clk)
    if (!sram_we_n) mem[sram_addr] <= sram_dq;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (read_en | write_en)) begin
      if (!sram_we_n) begin
        we_cnt++;
        if (q.size() > 0) begin
          chk("wr_addr", 256'(sram_addr), 256'(q[0].word));
          chk("wr_dq", 256'(sram_dq), 256'(q[0].wdata));
        end
      end
      if (!sram_oe_n) oe_cnt++;
      if (!ready) begin
        lat++;
      end else begin
        if (q.size() == 0) begin
          chk("unexpected_ready", 256'(q.size()), 256'(1));
        end else begin
          e = q.pop_front();
          chk("latency", 256'(lat), 256'(e.lat));
          chk("we_cycles", 256'(we_cnt), 256'(e.rd ? 0 : W));
          chk("oe_cycles", 256'(oe_cnt), 256'(e.rd ? RW*W : 0));
          if (e.rd) chk("read_data", 256'(read_data), 256'(e.rdata));
        end
        lat = 0;
        we_cnt = 0;
        oe_cnt = 0;
      end
    end
  end

  task automatic issue(bit rd, bit wr, logic [31:0] addr, logic [DW-1:0] d);
    exp_t x;
    int word;
    int base;
    bit got;
    word = int'((addr - BASE) >> 2);
    x.rd = rd;
    x.word = word[AW-1:0];
    x.wdata = d;
    x.rdata = '0;
    if (rd) begin
      base = word & ~(RW - 1);
      for (int i = 0; i < RW; i++) x.rdata[i*DW +: DW] = ref_mem[base+i];
      x.lat = RW * W + 1;
    end else begin
      ref_mem[word] = d;
      x.lat = W + 1;
    end
    q.push_back(x);
    read_en = rd;
    write_en = wr;
    address = addr;
    write_data = d;
    got = 0;
    repeat (100) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 256'(got), 256'(1));
    @(posedge clk);
    #1;
    read_en = 0;
    write_en = 0;
  endtask

  initial begin
    int r;
    int word;
    int gap;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    ref_mem[2] = 32'hCAFEF00D;
    mem[2] = 32'hCAFEF00D;

    #12;
    chk("rst_ready", 256'(ready), 256'(0));
    chk("rst_we_n", 256'(sram_we_n), 256'(1));
    chk("rst_oe_n", 256'(sram_oe_n), 256'(1));
    chk("rst_addr", 256'(sram_addr), 256'(0));
    chk("rst_rdata", 256'(read_data), 256'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready", 256'(ready), 256'(1));

    write_en = 1;
    address = BASE + 32'd20;
    write_data = ref_mem[5];
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("wr_active_we_n", 256'(sram_we_n), 256'(0));
    rst_n = 0;
    #1;
    chk("midwr_rst_we_n", 256'(sram_we_n), 256'(1));
    chk("midwr_rst_ready", 256'(ready), 256'(0));
    chk("midwr_rst_oe_n", 256'(sram_oe_n), 256'(1));
    write_en = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 256'(ready), 256'(1));

    @(posedge clk);
    #1;
    mon_en = 1;
    issue(1, 0, 32'h408, 32'h0);
    issue(0, 1, 32'h408, 32'hDEADBEEF);
    issue(1, 0, 32'h408, 32'h0);
    issue(1, 1, 32'h40C, 32'h12345678);
    issue(1, 0, 32'h40C, 32'h0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      word = $urandom_range(0, 255);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      issue(r != 2, r >= 2, BASE + 32'(word * 4) + 32'($urandom_range(0, 3)),
            DW'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
